rdyacpt_burst_src: RTL and testbench
====================================

RDYACPT_BURST_SRC -- requirements
Module: rdyacpt_burst_src

Interface
REQ-001 Parameter: WIDTH, 8, data width of start_data and downstream_data.
REQ-002 Parameter: CNT_W, 8, width of count.
REQ-003 Parameter: GAP_W, 4, width of gap.
REQ-004 clk  input  1  sole clock; all state changes on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  command strobe, sampled only in IDLE.
REQ-007 start_data  input  WIDTH  first data word of the burst.
REQ-008 count  input  CNT_W  number of words in the burst.
REQ-009 gap  input  GAP_W  idle cycles inserted between words.
REQ-010 busy  output  1  high while a burst is in progress (SEND or GAP).
REQ-011 done  output  1  one-cycle pulse when a burst completes.
REQ-012 downstream_rdy  output  1  word valid, rdy/acpt protocol.
REQ-013 downstream_acpt  input  1  consumer accepts the current word.
REQ-014 downstream_data  output  WIDTH  current word.

Function
REQ-015 A transfer SHALL occur on a posedge with downstream_rdy=1 and downstream_acpt=1.
REQ-016 All outputs SHALL be registered; no combinational path from downstream_acpt to any output.
REQ-017 The FSM SHALL have four states: IDLE, SEND, GAP, DONE.
REQ-018 IDLE: start=1 and count!=0 latch count and gap, load start_data, go to SEND; downstream_rdy=1 on the next cycle.
REQ-019 IDLE: start=1 and count=0 go to DONE without any transfer.
REQ-020 Once downstream_rdy is high, it and downstream_data SHALL stay constant until a transfer.
REQ-021 SEND, transfer, last word (remaining=1): downstream_rdy=0, go to DONE.
REQ-022 SEND, transfer, not last, latched gap=0: stay in SEND, rdy stays 1, data increments by 1 on the next cycle (back-to-back, one word per clock).
REQ-023 SEND, transfer, not last, latched gap=G>0: rdy=0, go to GAP for exactly G cycles, then SEND with the data incremented.
REQ-024 Data increment SHALL wrap modulo 2^WIDTH (for WIDTH=8, 8'hFF -> 8'h00).
REQ-025 The remaining counter SHALL decrement by one per transfer only; the burst SHALL produce exactly count transfers.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 start SHALL be ignored in SEND, GAP and DONE; an accepted command in IDLE SHALL take effect from the next clock.
REQ-028 busy SHALL be 1 in SEND and GAP, and 0 in IDLE and DONE.
REQ-029 Changes to count, gap or start_data during a burst SHALL have no effect.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, with downstream_rdy=0, busy=0, done=0, downstream_data=0, and remaining and gap counters at 0.
REQ-031 Reset mid-burst SHALL abandon the burst; after release, no word is presented until a new start.

Structure
REQ-032 No shared package; state encodings SHALL be local parameters of this module.
REQ-033 Single flat module; no sub-module.
REQ-034 Size target: 120-400 lines.

Verification
REQ-035 start, start_data=8'h10, count=4, gap=0, acpt tied 1 -> words 10,11,12,13 on four consecutive clocks, then done=1 for one cycle.
REQ-036 count=3, gap=2, acpt=1 -> each transfer followed by exactly 2 cycles with rdy=0, then 3 transfers and one done pulse.
REQ-037 count=2, acpt held 0 for 5 cycles after rdy rises -> rdy and data (start_data) held stable for all 5 cycles, then 2 transfers complete.
REQ-038 start_data=8'hFE, count=3, gap=0 -> words FE, FF, 00.
REQ-039 count=0 with start -> no rdy assertion, done=1 one cycle later; start pulsed while busy -> ignored.
REQ-040 reset_n asserted during the second word of a count=5 burst -> rdy, busy and done go to 0 immediately; no words after release until a new start.

Source files
------------

// File: rtl/rdyacpt_burst_src.sv
// -----------------------------------------------------------------------------
// rdyacpt_burst_src
//
// Burst word source with a rdy/acpt handshake.
// A start command taken in IDLE loads a first data word, a word count and an
// inter-word gap. The block then presents count words, each one greater than
// the previous (wrapping modulo 2^WIDTH). After each accepted word except the
// last it idles for gap cycles. A one-cycle done pulse marks the end of the
// burst.
//
// Ports
//   clk              sole clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            command strobe, only looked at in IDLE
//   start_data       first word of the burst
//   count            number of words in the burst (0 = empty burst)
//   gap              idle cycles between consecutive words
//   busy             high in SEND and GAP
//   done             one-cycle pulse when a burst completes
//   downstream_rdy   current word valid
//   downstream_acpt  consumer takes the current word
//   downstream_data  current word
//
// All outputs come straight from flops, so there is no combinational path
// from downstream_acpt to any output.
// -----------------------------------------------------------------------------
module rdyacpt_burst_src #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_data,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             busy,
    output logic             done,
    output logic             downstream_rdy,
    input  logic             downstream_acpt,
    output logic [WIDTH-1:0] downstream_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;   // words still to transfer, including the current one
    logic [GAP_W-1:0] gap_lat;     // gap length captured at start
    logic [GAP_W-1:0] gap_cnt;     // idle cycles left in the current GAP
    logic             xfer;

    assign xfer = downstream_rdy & downstream_acpt;

    // Next-state logic. In SEND downstream_rdy is always high, so a transfer
    // reduces to downstream_acpt being high.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end else if (gap_lat == '0) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                // gap_cnt was loaded with G (> 0); leaving on 1 gives exactly G cycles.
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = SEND;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Output flags are decoded from the next state so that
    // they are registered and line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments for all flops, so every block sees pre-edge values.
            state          <= IDLE;
            downstream_rdy <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            downstream_rdy <= (state_nxt == SEND);
            busy           <= (state_nxt == SEND) || (state_nxt == GAP);
            done           <= (state_nxt == DONE);
        end
    end

    // Datapath: burst parameters, word counter, gap counter and output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining       <= '0;
            gap_lat         <= '0;
            gap_cnt         <= '0;
            downstream_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        remaining       <= count;
                        gap_lat         <= gap;
                        downstream_data <= start_data;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        remaining <= remaining - CNT_W'(1);
                        // Advance only when another word follows. The next word
                        // is prepared while rdy is low (GAP) or shown directly
                        // on the next cycle (gap 0).
                        if (remaining != CNT_W'(1)) begin
                            downstream_data <= downstream_data + WIDTH'(1);
                        end
                        if (state_nxt == GAP) begin
                            gap_cnt <= gap_lat;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdyacpt_burst_src.sv
// -----------------------------------------------------------------------------
// tb_rdyacpt_burst_src
//
// Self-checking bench for rdyacpt_burst_src. For each burst an expected
// waveform (rdy, data, busy, done per cycle) is built from the burst rules and
// a pre-drawn accept pattern. Outputs are sampled on the falling edge and
// compared against that waveform.
// -----------------------------------------------------------------------------
module tb_rdyacpt_burst_src;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam int MAXC  = 256;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] start_data;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             busy;
    logic             done;
    logic             downstream_rdy;
    logic             downstream_acpt;
    logic [WIDTH-1:0] downstream_data;

    int n_checks;
    int n_pass;

    // Accept pattern: acpt_pat[k] is driven after sample k and is seen by the
    // DUT on the following rising edge.
    logic             acpt_pat [MAXC];
    logic             e_rdy    [MAXC];
    logic             e_busy   [MAXC];
    logic             e_done   [MAXC];
    logic [WIDTH-1:0] e_data   [MAXC];
    int               e_len;

    rdyacpt_burst_src #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_data     (start_data),
        .count          (count),
        .gap            (gap),
        .busy           (busy),
        .done           (done),
        .downstream_rdy (downstream_rdy),
        .downstream_acpt(downstream_acpt),
        .downstream_data(downstream_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: always accept; 1: random (about 70 %); 2: refuse for the first
    // five cycles, then always accept.
    task automatic make_acpt(input int mode);
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       acpt_pat[i] = 1'b1;
                1:       acpt_pat[i] = (i > 150) ? 1'b1 : ($urandom_range(9, 0) < 7);
                default: acpt_pat[i] = (i >= 1 && i <= 5) ? 1'b0 : 1'b1;
            endcase
        end
    endtask

    // Expected waveform from the burst rules. Sample 1 is the first cycle after
    // the edge that takes the start command.
    task automatic build_model(input logic [WIDTH-1:0] d, input int n, input int g);
        int k;
        int w;
        for (int i = 0; i < MAXC; i++) begin
            e_rdy[i]  = 1'b0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_data[i] = '0;
        end
        k = 1;
        w = 0;
        if (n == 0) begin
            e_done[1] = 1'b1;
            k = 2;
        end else begin
            while (w < n) begin
                e_rdy[k]  = 1'b1;
                e_busy[k] = 1'b1;
                e_data[k] = d + WIDTH'(w);
                if (acpt_pat[k]) begin
                    w++;
                    k++;
                    if (w < n) begin
                        for (int j = 0; j < g; j++) begin
                            e_busy[k] = 1'b1;
                            k++;
                        end
                    end
                end else begin
                    k++;
                end
            end
            e_done[k] = 1'b1;
            k++;
        end
        e_len = k + 2;
    endtask

    // Runs one burst and compares every sampled cycle against the model.
    // With scramble set, start/count/gap/start_data are randomised whenever
    // the DUT is expected to be in SEND, GAP or DONE, where they must be ignored.
    task automatic run_burst(input string name, input logic [WIDTH-1:0] d,
                             input int n, input int g, input bit scramble);
        build_model(d, n, g);
        @(negedge clk);
        start           = 1'b1;
        start_data      = d;
        count           = CNT_W'(n);
        gap             = GAP_W'(g);
        downstream_acpt = 1'b0;
        for (int k = 1; k < e_len; k++) begin
            @(negedge clk);
            n_checks++;
            if (downstream_rdy !== e_rdy[k]) $display("FAIL %s rdy cyc%0d got %b exp %b", name, k, downstream_rdy, e_rdy[k]);
            else n_pass++;
            n_checks++;
            if (busy !== e_busy[k]) $display("FAIL %s busy cyc%0d got %b exp %b", name, k, busy, e_busy[k]);
            else n_pass++;
            n_checks++;
            if (done !== e_done[k]) $display("FAIL %s done cyc%0d got %b exp %b", name, k, done, e_done[k]);
            else n_pass++;
            if (e_rdy[k]) begin
                n_checks++;
                if (downstream_data !== e_data[k]) $display("FAIL %s data cyc%0d got %h exp %h", name, k, downstream_data, e_data[k]);
                else n_pass++;
            end
            downstream_acpt = acpt_pat[k];
            if (scramble && (e_busy[k] || e_done[k])) begin
                start      = 1'($urandom);
                count      = CNT_W'($urandom);
                gap        = GAP_W'($urandom);
                start_data = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        start           = 1'b0;
        start_data      = '0;
        count           = '0;
        gap             = '0;
        downstream_acpt = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({downstream_rdy, busy, done} !== 3'b000 || downstream_data !== '0)
            $display("FAIL reset_hold got rdy%b busy%b done%b data%h exp 0", downstream_rdy, busy, done, downstream_data);
        else n_pass++;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({downstream_rdy, busy, done} !== 3'b000)
                $display("FAIL reset_release got rdy%b busy%b done%b exp 000", downstream_rdy, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        make_acpt(0);
        run_burst("b2b", 8'h10, 4, 0, 1'b0);
    endtask

    task automatic test_gap();
        make_acpt(0);
        run_burst("gap2", 8'h40, 3, 2, 1'b0);
    endtask

    task automatic test_backpressure();
        make_acpt(2);
        run_burst("backpressure", 8'h5A, 2, 0, 1'b0);
    endtask

    task automatic test_wrap();
        make_acpt(0);
        run_burst("wrap", 8'hFE, 3, 0, 1'b0);
    endtask

    task automatic test_zero_count();
        make_acpt(0);
        run_burst("count0", 8'h77, 0, 0, 1'b0);
        make_acpt(1);
        run_burst("start_ignored", 8'h21, 4, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            make_acpt(1);
            run_burst("random", WIDTH'($urandom), $urandom_range(6, 0), $urandom_range(3, 0), 1'b1);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        start           = 1'b1;
        start_data      = 8'h30;
        count           = 8'd5;
        gap             = '0;
        downstream_acpt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (downstream_rdy !== 1'b1 || downstream_data !== 8'h31)
            $display("FAIL mid_reset second_word got rdy%b data%h exp 1 31", downstream_rdy, downstream_data);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({downstream_rdy, busy, done} !== 3'b000 || downstream_data !== '0)
            $display("FAIL mid_reset async got rdy%b busy%b done%b data%h exp 0", downstream_rdy, busy, done, downstream_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if ({downstream_rdy, busy, done} !== 3'b000)
                $display("FAIL mid_reset after_release got rdy%b busy%b done%b exp 000", downstream_rdy, busy, done);
            else n_pass++;
        end
        make_acpt(0);
        run_burst("after_reset", 8'h88, 2, 1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_back_to_back();
        test_gap();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
